// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg: shared constants and types for the sequenced execute-stage ALU.
//   - RV "OP" (R-type) opcode, funct3/funct7 encodings for base and M ops
//   - default operand width
//   - FSM state type and decoded instruction-control payload
//   - small decode helpers shared by alu_seq and muldiv_iter
// Optional feature macro used by the consumers: ALU_SEQ_MULDIV_EN.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    // Default operand/result width.
    localparam int unsigned XLEN_DEFAULT = 32;

    // R-type opcode and funct7 selectors.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    // Base funct3 encodings.
    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // M-extension funct3 encodings.
    localparam logic [2:0] F3_MUL     = 3'b000;
    localparam logic [2:0] F3_MULH    = 3'b001;
    localparam logic [2:0] F3_MULHSU  = 3'b010;
    localparam logic [2:0] F3_MULHU   = 3'b011;
    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // Decoded control fields of an incoming operation.
    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
        logic [6:0] opcode;
    } inst_ctl_t;

    // Base ops: funct7 all-zero for every funct3, alt funct7 only for SUB and SRA.
    function automatic logic base_legal(input logic [2:0] f3, input logic [6:0] f7);
        return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic md_rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic md_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// -----------------------------------------------------------------------------
// muldiv_iter: iterative multiply/divide datapath for alu_seq
// (only built when ALU_SEQ_MULDIV_EN is defined).
//   Multiply: shift-add, one multiplier bit per cycle into a 2*XLEN product.
//   Divide:   restoring, one quotient bit per cycle.
// Operands are reduced to magnitudes at start; signs are reapplied on the
// combinational result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           load operands and begin XLEN iterations
//   funct3          M-op selector, sampled at start
//   rs1, rs2        source operands, sampled at start
//   last_c          the coming edge performs the final iteration
//   result_c        sign-corrected result, valid once iterations are complete
// -----------------------------------------------------------------------------
`ifdef ALU_SEQ_MULDIV_EN
module muldiv_iter
    import alu_seq_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            last_c,
    output logic [XLEN-1:0] result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    // acc: {product_hi, product_lo} for multiply, {remainder, dividend/quotient} for divide.
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [CNT_W-1:0]  cnt;
    logic              active;
    logic              is_div;
    logic              sel_alt;
    logic              neg_a;
    logic              neg_r;

    logic              s1_neg_c;
    logic              s2_neg_c;
    logic [XLEN-1:0]   mag1_c;
    logic [XLEN-1:0]   mag2_c;
    logic [XLEN:0]     mul_sum_c;
    logic [XLEN:0]     div_shift_c;
    logic [XLEN:0]     div_diff_c;
    logic              div_ge_c;
    logic [2*XLEN-1:0] step_c;
    logic [2*XLEN-1:0] prod_c;
    logic [XLEN-1:0]   quot_c;
    logic [XLEN-1:0]   rem_c;

    // Operand magnitudes at start.
    always_comb begin
        s1_neg_c = md_rs1_signed(funct3) && rs1[XLEN-1];
        s2_neg_c = md_rs2_signed(funct3) && rs2[XLEN-1];
        mag1_c   = s1_neg_c ? (XLEN'(0) - rs1) : rs1;
        mag2_c   = s2_neg_c ? (XLEN'(0) - rs2) : rs2;
    end

    // One shift-add or restoring-subtract step.
    always_comb begin
        mul_sum_c   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : XLEN'(0))};
        div_shift_c = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge_c    = (div_shift_c >= {1'b0, opnd});
        div_diff_c  = div_shift_c - {1'b0, opnd};
        if (is_div) begin
            step_c = {(div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0]),
                      acc[XLEN-2:0], div_ge_c};
        end else begin
            step_c = {mul_sum_c, acc[XLEN-1:1]};
        end
    end

    // Operand load and iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            opnd    <= '0;
            cnt     <= '0;
            active  <= 1'b0;
            is_div  <= 1'b0;
            sel_alt <= 1'b0;
            neg_a   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (start) begin
            active  <= 1'b1;
            cnt     <= '0;
            is_div  <= funct3[2];
            // Upper product half for MULH*, remainder for REM*.
            sel_alt <= funct3[2] ? funct3[1] : (funct3 != F3_MUL);
            // Divide by zero keeps an all-ones quotient regardless of sign.
            neg_a   <= (s1_neg_c ^ s2_neg_c) && (!funct3[2] || (rs2 != '0));
            neg_r   <= s1_neg_c;
            if (funct3[2]) begin
                acc  <= {XLEN'(0), mag1_c};
                opnd <= mag2_c;
            end else begin
                acc  <= {XLEN'(0), mag2_c};
                opnd <= mag1_c;
            end
        end else if (active) begin
            acc <= step_c;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
                active <= 1'b0;
            end
        end
    end

    assign last_c = active && (cnt == CNT_W'(XLEN - 1));

    // Sign correction of the finished magnitudes.
    always_comb begin
        prod_c   = neg_a ? ((2*XLEN)'(0) - acc) : acc;
        quot_c   = neg_a ? (XLEN'(0) - acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem_c    = neg_r ? (XLEN'(0) - acc[2*XLEN-1:XLEN]) : acc[2*XLEN-1:XLEN];
        if (is_div) begin
            result_c = sel_alt ? rem_c : quot_c;
        end else begin
            result_c = sel_alt ? prod_c[2*XLEN-1:XLEN] : prod_c[XLEN-1:0];
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq: handshaked execute-stage integer ALU.
//   Base R-type ops complete with latency 1. With ALU_SEQ_MULDIV_EN defined,
//   M-extension ops run on muldiv_iter (XLEN iterations + one fix-up cycle);
//   without it they are reported illegal at latency 1 and busy is tied low.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       operation handshake (in_ready has no in_valid path)
//   opcode, funct3, funct7    instruction fields
//   rs1, rs2                  source operands
//   out_valid / out_ready     result handshake
//   rd, illegal               result and unrecognised-op flag, held under backpressure
//   busy                      iterative op in progress
// -----------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEFAULT,
    parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd,
    output logic            illegal,
    output logic            busy
);

    state_t          state;
    inst_ctl_t       ctl_c;
    logic [XLEN-1:0] alu_c;
    logic            base_ok_c;
    logic            accept_c;
    logic [SHAMT_W-1:0] shamt_c;

    assign ctl_c     = '{funct7: funct7, funct3: funct3, opcode: opcode};
    assign shamt_c   = rs2[SHAMT_W-1:0];
    assign base_ok_c = (ctl_c.opcode == OPC_OP) && base_legal(ctl_c.funct3, ctl_c.funct7);
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept_c  = in_valid && in_ready;

    // Single-cycle base ALU.
    always_comb begin
        alu_c = '0;
        case (ctl_c.funct3)
            F3_ADD:  alu_c = ctl_c.funct7[5] ? (rs1 - rs2) : (rs1 + rs2);
            F3_SLL:  alu_c = rs1 << shamt_c;
            F3_SLT:  alu_c = XLEN'($signed(rs1) < $signed(rs2));
            F3_SLTU: alu_c = XLEN'(rs1 < rs2);
            F3_XOR:  alu_c = rs1 ^ rs2;
            F3_SR:   alu_c = ctl_c.funct7[5] ? XLEN'($signed(rs1) >>> shamt_c) : (rs1 >> shamt_c);
            F3_OR:   alu_c = rs1 | rs2;
            F3_AND:  alu_c = rs1 & rs2;
            default: alu_c = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic            md_ok_c;
    logic            md_last_c;
    logic [XLEN-1:0] md_result_c;
    logic            busy_q;

    assign md_ok_c = (ctl_c.opcode == OPC_OP) && (ctl_c.funct7 == F7_MULDIV);
    assign busy    = busy_q;

    muldiv_iter #(
        .XLEN (XLEN)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (accept_c && md_ok_c),
        .funct3   (ctl_c.funct3),
        .rs1      (rs1),
        .rs2      (rs2),
        .last_c   (md_last_c),
        .result_c (md_result_c)
    );
`else
    assign busy = 1'b0;
`endif

    // Control FSM and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            rd        <= '0;
            illegal   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            busy_q    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (accept_c) begin
`ifdef ALU_SEQ_MULDIV_EN
                        if (md_ok_c) begin
                            state  <= ST_ITER;
                            busy_q <= 1'b1;
                        end else
`endif
                        begin
                            // Unrecognised ops return zero with the illegal flag.
                            rd        <= base_ok_c ? alu_c : '0;
                            illegal   <= !base_ok_c;
                            out_valid <= 1'b1;
                        end
                    end
                end
`ifdef ALU_SEQ_MULDIV_EN
                ST_ITER: begin
                    if (md_last_c) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    rd        <= md_result_c;
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq: directed bench for alu_seq. Expected results are queued when an
// operation is accepted and compared when the result is taken.
// Expectations for M ops follow ALU_SEQ_MULDIV_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq;

    localparam int unsigned XLEN = 32;
    localparam logic [6:0]  OP   = 7'b0110011;
    localparam logic [6:0]  F7B  = 7'b0000000;
    localparam logic [6:0]  F7A  = 7'b0100000;
    localparam logic [6:0]  F7M  = 7'b0000001;
`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] rd;
    logic            illegal;
    logic            busy;

    alu_seq #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7    (funct7),
        .rs1       (rs1),
        .rs2       (rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .illegal   (illegal),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        ill;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc_n      = 0;
    bit   fired;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: sample just after the negedge, score outputs, log accepts.
    task automatic cyc();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            chk("unexpected_output", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.tag, "_rd"}, rd, e.rd);
                chk({e.tag, "_illegal"}, 32'(illegal), 32'(e.ill));
                if (e.lat >= 0) chk({e.tag, "_latency"}, 32'(cyc_n - e.acc), 32'(e.lat));
            end
        end
        fired = 1'b0;
        if (in_valid && in_ready && !rst) begin
            e     = pend;
            e.acc = cyc_n;
            sb.push_back(e);
            fired = 1'b1;
        end
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic set_in(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic ill, input int lat);
        opcode   = opc;
        funct3   = f3;
        funct7   = f7;
        rs1      = a;
        rs2      = b;
        pend.tag = tag;
        pend.rd  = exp;
        pend.ill = ill;
        pend.lat = lat;
        pend.acc = 0;
        in_valid = 1'b1;
    endtask

    task automatic issue(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic ill, input int lat);
        set_in(tag, opc, f3, f7, a, b, exp, ill, lat);
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (fired) break;
        end
        chk({tag, "_accepted"}, 32'(fired), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
        issue(tag, OP, f3, F7M, a, b, MD ? exp : 32'h0, !MD, MD ? int'(XLEN) + 1 : 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; funct3 = '0; funct7 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rd", rd, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back base ops at one per cycle.
        issue("add",  OP, 3'b000, F7B, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        issue("sub",  OP, 3'b000, F7A, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        issue("sra",  OP, 3'b101, F7A, 32'h8000_0000, 32'h24, 32'hF800_0000, 1'b0, 1);
        issue("srl",  OP, 3'b101, F7B, 32'h8000_0000, 32'h24, 32'h0800_0000, 1'b0, 1);
        issue("slt",  OP, 3'b010, F7B, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        issue("sltu", OP, 3'b011, F7B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1);
        issue("sll",  OP, 3'b001, F7B, 32'h1, 32'h3F, 32'h8000_0000, 1'b0, 1);
        issue("and",  OP, 3'b111, F7B, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
        issue("bad_opc", 7'b0010011, 3'b000, F7B, 32'd5, 32'd7, 32'd0, 1'b1, 1);
        issue("bad_f7",  OP, 3'b001, F7A, 32'd5, 32'd7, 32'd0, 1'b1, 1);
        drain();

        // M ops (illegal at latency 1 when the iterative datapath is absent).
        md("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        md("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        md("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        md("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        md("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        md("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        md("divu0",  3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        md("remu0",  3'b111, 32'h0000_1234, 32'd0, 32'h0000_1234);
        md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        drain();

        // Backpressure: result and illegal held, no accept, then release.
        out_ready = 1'b0;
        issue("bp_xor", OP, 3'b100, F7B, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, -1);
        set_in("bp_or", OP, 3'b110, F7B, 32'h00FF_0000, 32'h0000_FF00, 32'h00FF_FF00, 1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_rd_stable", rd, 32'hFF00_FF00);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_no_accept", 32'(fired), 32'd0);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release_accept", 32'(fired), 32'd1);
        drain();

        // Reset during an operation discards it.
`ifdef ALU_SEQ_MULDIV_EN
        issue("rst_div", OP, 3'b100, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        repeat (9) cyc();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_out_valid", 32'(out_valid), 32'd0);
`else
        out_ready = 1'b0;
        issue("rst_add", OP, 3'b000, F7B, 32'd3, 32'd4, 32'd7, 1'b0, -1);
        cyc();
        chk("held_out_valid", 32'(out_valid), 32'd1);
`endif
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_rd", rd, 32'd0);
        chk("post_rst_illegal", 32'(illegal), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        issue("add_after_rst", OP, 3'b000, F7B, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle integer ALU in the execute stage. Executes RV base R-type ops in one registered cycle and, when compiled in, the M-extension multiply/divide ops on a shared iterative datapath. Sits between the decode/register-read stage and writeback, using valid/ready on both sides so a multi-cycle op stalls the pipeline cleanly.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8.
- `SHAMT_W`, `$clog2(XLEN)`: shift-amount width. Derived; do not override.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: operation presented.
- `in_ready`  out  1: operation accepted on an edge where `in_valid && in_ready`.
- `opcode`  in  7: instruction opcode.
- `funct3`  in  3: instruction funct3.
- `funct7`  in  7: instruction funct7.
- `rs1`, `rs2`  in  XLEN each: source operands.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes the result on an edge where `out_valid && out_ready`.
- `rd`  out  XLEN: result.
- `illegal`  out  1: the op was not recognised; qualified by `out_valid`.
- `busy`  out  1: iterative op in progress.

## Operation
- States: IDLE, ITER, FIX, HOLD.
- `in_ready` = (state==IDLE) && (!out_valid || out_ready).
- Base ops use `funct7[5]` to select SUB vs ADD and SRA vs SRL. SLT is signed. SLTU is unsigned. Shifts use `rs2[SHAMT_W-1:0]`. Result is registered at the accept edge; state stays IDLE.
- M ops (`funct7`=0000001): MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Operands are converted to magnitudes at accept; IDLE→ITER.
  - Mul: shift-add, one bit per cycle, 2·XLEN product register.
  - Div: restoring, one quotient bit per cycle.
  - Counter runs XLEN iterations, then ITER→FIX. FIX applies sign correction, writes `rd`, and sets `out_valid`; FIX→HOLD.
  - HOLD→IDLE when `out_ready` is high.
- Divide by zero: quotient = all ones, remainder = `rs1`. Completes with the normal latency; no trap.
- Signed overflow (`rs1` = 1<<(XLEN-1), `rs2` = −1): DIV → `rs1`, REM → 0.
- Unknown opcode/funct combination: `rd`=0, `illegal`=1, single-cycle path.
- Backpressure: while `out_valid && !out_ready`, `rd` and `illegal` hold stable and no new op is accepted.
- Reset (including mid-iteration): state IDLE, `out_valid`=0, `rd`=0, `illegal`=0, `busy`=0, counter=0. The in-flight op is discarded.

## Timing
- Base op accepted at edge E: `out_valid` is high after E (latency 1).
- Back-to-back base ops sustain one per cycle while `out_ready`=1.
- M op accepted at edge E:
  - Iterations occur on edges E+1 … E+XLEN.
  - FIX registers the result at E+XLEN+1; `out_valid` is high after that edge.
  - `busy`=1 from after E until the FIX edge.
- `in_ready` is combinational from state, `out_valid`, and `out_ready`. No combinational path from `in_valid` to `in_ready`.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: M ops supported as above.
- Undefined:
  - Iterative datapath, ITER/FIX states and the counter are removed.
  - `funct7`=0000001 reports `illegal`=1.
  - `busy` is tied to 0.
  - Every op has latency 1.

## Structure
- Add to the shared define headers:
  - In `inst.v`: opcode, funct3 and funct7 constants for OP type R (base and M).
  - In `const.v`: default `XLEN`.
- Sub-module `muldiv_iter`: holds the magnitude registers, counter, and shift-add/restoring step. Exposes start/done/result. Instantiated only under `ALU_SEQ_MULDIV_EN`.
- `alu_seq` owns the base ALU, the FSM, the output register and the handshake.

## Test plan
- ADD 5+7, then SUB (`funct7`=0100000) 5−7, back-to-back with `out_ready`=1:
  - `rd` = 12, then 0xFFFFFFFE, on consecutive cycles.
  - `illegal`=0.
- SRA 0x80000000 by `rs2`=0x24 (uses 4) → 0xF8000000. SRL → 0x08000000. SLT −1<1 → 1. SLTU → 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MUL 7×−3 → 0xFFFFFFEB. `out_valid` is exactly XLEN+1 cycles after accept.
- DIV −7/2 → 0xFFFFFFFD, REM → 0xFFFFFFFF. DIVU x/0 → 0xFFFFFFFF. REM 0x80000000/−1 → 0.
- Hold `out_ready`=0 for 5 cycles after a result:
  - `rd` stays stable and `in_ready`=0.
  - Release → next op is accepted the same cycle.
- Assert `rst` at iteration 10 of a DIV: all outputs return to 0 the next cycle, and a following ADD completes with latency 1. Without the macro, MUL reports `illegal`=1 at latency 1.
